// File: rtl/decoder_pulse_seq.sv
// decoder_pulse_seq
//   Registered 3-to-8 one-hot decoder with a valid/ready input handshake.
//   Each accepted CODE drives a one-hot DATA pulse for PULSE_LEN cycles,
//   followed by a GAP_LEN-cycle guard gap with DATA at zero, before
//   CODE_READY reasserts. Codes offered while busy are dropped and counted.
//
//   Optional feature: define DECODER_PULSE_PARITY_EN to add CODE_PAR/PAR_ERR.
//   An accept then also requires odd parity over {CODE, CODE_PAR}. With even
//   parity no pulse is started and PAR_ERR pulses for one cycle.
//
// Ports:
//   CLK         in   rising-edge clock
//   RST_N       in   synchronous active-low reset
//   CODE[2:0]   in   binary code to decode
//   CODE_VALID  in   CODE is valid this cycle
//   CODE_PAR    in   parity bit for CODE (DECODER_PULSE_PARITY_EN only)
//   CODE_READY  out  block accepts CODE at this edge (registered)
//   DATA[7:0]   out  one-hot decoded output, zero when idle
//   DATA_VALID  out  high while DATA carries a pulse
//   DROP        out  one-cycle pulse: CODE_VALID seen while not ready
//   PAR_ERR     out  one-cycle parity error pulse (DECODER_PULSE_PARITY_EN only)
//   DROP_CNT    out  saturating count of dropped codes
module decoder_pulse_seq #(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] CODE,
  input  logic       CODE_VALID,
`ifdef DECODER_PULSE_PARITY_EN
  input  logic       CODE_PAR,
  output logic       PAR_ERR,
`endif
  output logic       CODE_READY,
  output logic [7:0] DATA,
  output logic       DATA_VALID,
  output logic       DROP,
  output logic [7:0] DROP_CNT
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } state_e;

  localparam logic [7:0] PULSE_RELOAD = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GAP_RELOAD   = 8'(GAP_LEN - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       dv_q, dv_d;
  logic       ready_q, ready_d;
  logic       drop_q, drop_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic       par_ok;

`ifdef DECODER_PULSE_PARITY_EN
  logic       parerr_q, parerr_d;
  assign par_ok  = ^{CODE, CODE_PAR};
  assign PAR_ERR = parerr_q;
`else
  assign par_ok  = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    dv_d    = dv_q;
    ready_d = ready_q;
    drop_d  = CODE_VALID & ~ready_q;
    dcnt_d  = (drop_d && (dcnt_q != 8'hFF)) ? dcnt_q + 8'd1 : dcnt_q;
`ifdef DECODER_PULSE_PARITY_EN
    parerr_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // Ready is raised here so the first edge after reset release arms it.
        ready_d = 1'b1;
        if (CODE_VALID && ready_q) begin
          if (par_ok) begin
            data_d  = 8'h01 << CODE;
            dv_d    = 1'b1;
            ready_d = 1'b0;
            cnt_d   = PULSE_RELOAD;
            state_d = DRIVE;
          end else begin
`ifdef DECODER_PULSE_PARITY_EN
            parerr_d = 1'b1;
`endif
          end
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          data_d = '0;
          dv_d   = 1'b0;
          if (GAP_LEN == 0) begin
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = GAP_RELOAD;
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      ready_q <= 1'b0;
      drop_q  <= 1'b0;
      dcnt_q  <= '0;
`ifdef DECODER_PULSE_PARITY_EN
      parerr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      ready_q <= ready_d;
      drop_q  <= drop_d;
      dcnt_q  <= dcnt_d;
`ifdef DECODER_PULSE_PARITY_EN
      parerr_q <= parerr_d;
`endif
    end
  end

  assign CODE_READY = ready_q;
  assign DATA       = data_q;
  assign DATA_VALID = dv_q;
  assign DROP       = drop_q;
  assign DROP_CNT   = dcnt_q;

endmodule

// File: tb/tb_decoder_pulse_seq.sv
// Testbench for decoder_pulse_seq: two instances (defaults, and
// PULSE_LEN=1/GAP_LEN=0) checked against a time-based reference model,
// plus a table of hand-derived vectors for the default instance.
module tb_decoder_pulse_seq;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [2:0] CODE;
  logic       CODE_VALID;
  always #5 CLK = ~CLK;

  logic       rdy_o  [2];
  logic [7:0] data_o [2];
  logic       dv_o   [2];
  logic       drop_o [2];
  logic [7:0] cnt_o  [2];

`ifdef DECODER_PULSE_PARITY_EN
  logic CODE_PAR;
  logic bad_par;
  logic perr_o [2];
`endif

  decoder_pulse_seq #(.PULSE_LEN(4), .GAP_LEN(1)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .CODE(CODE), .CODE_VALID(CODE_VALID),
`ifdef DECODER_PULSE_PARITY_EN
    .CODE_PAR(CODE_PAR), .PAR_ERR(perr_o[0]),
`endif
    .CODE_READY(rdy_o[0]), .DATA(data_o[0]), .DATA_VALID(dv_o[0]),
    .DROP(drop_o[0]), .DROP_CNT(cnt_o[0])
  );

  decoder_pulse_seq #(.PULSE_LEN(1), .GAP_LEN(0)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .CODE(CODE), .CODE_VALID(CODE_VALID),
`ifdef DECODER_PULSE_PARITY_EN
    .CODE_PAR(CODE_PAR), .PAR_ERR(perr_o[1]),
`endif
    .CODE_READY(rdy_o[1]), .DATA(data_o[1]), .DATA_VALID(dv_o[1]),
    .DROP(drop_o[1]), .DROP_CNT(cnt_o[1])
  );

  int checks = 0;
  int errors = 0;
  int e = 0;  // edge counter

  // Reference model: tracks absolute edge numbers instead of states.
  int         m_pl [2] = '{4, 1};
  int         m_gl [2] = '{1, 0};
  int         m_ready_from [2] = '{1000000, 1000000};
  int         m_pulse_end  [2] = '{0, 0};
  logic [2:0] m_code [2];
  int         m_cnt  [2] = '{0, 0};
  logic       m_drop [2];
  logic       m_perr [2];

  task automatic chk(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d edge %0d: got %0d expected %0d", nm, i, e, act, exp);
    end
  endtask

  task automatic model_edge(input int i, input logic rst, input logic v,
                            input logic [2:0] c, input logic par_good);
    logic rdy;
    m_perr[i] = 1'b0;
    if (!rst) begin
      m_ready_from[i] = e + 2;
      m_pulse_end[i]  = e;
      m_cnt[i]        = 0;
      m_drop[i]       = 1'b0;
    end else begin
      rdy = (e >= m_ready_from[i]);
      m_drop[i] = v && !rdy;
      if (m_drop[i] && m_cnt[i] < 255) m_cnt[i]++;
      if (v && rdy) begin
        if (par_good) begin
          m_code[i]       = c;
          m_pulse_end[i]  = e + m_pl[i];
          m_ready_from[i] = e + m_pl[i] + m_gl[i] + 1;
        end else begin
          m_perr[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic [2:0] c);
    logic par_good;
    logic [7:0] exp_data;
    @(negedge CLK);
    RST_N      = rst;
    CODE_VALID = v;
    CODE       = c;
`ifdef DECODER_PULSE_PARITY_EN
    CODE_PAR = bad_par ? ^c : ~^c;
    par_good = ^{c, CODE_PAR};
`else
    par_good = 1'b1;
`endif
    @(posedge CLK);
    #1;
    e++;
    for (int i = 0; i < 2; i++) begin
      model_edge(i, rst, v, c, par_good);
      exp_data = (e < m_pulse_end[i]) ? (8'h01 << m_code[i]) : 8'h00;
      chk("data", i, int'(data_o[i]), int'(exp_data));
      chk("data_valid", i, int'(dv_o[i]), int'(e < m_pulse_end[i]));
      chk("code_ready", i, int'(rdy_o[i]), int'(e + 1 >= m_ready_from[i]));
      chk("drop", i, int'(drop_o[i]), int'(m_drop[i]));
      chk("drop_cnt", i, int'(cnt_o[i]), m_cnt[i]);
`ifdef DECODER_PULSE_PARITY_EN
      chk("par_err", i, int'(perr_o[i]), int'(m_perr[i]));
`endif
    end
  endtask

  typedef struct {
    logic       rst;
    logic       v;
    logic [2:0] code;
    logic [7:0] data;
    logic       dv;
    logic       rdy;
    logic       drop;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [12];

  initial begin
    RST_N = 1'b0; CODE_VALID = 1'b0; CODE = '0;
`ifdef DECODER_PULSE_PARITY_EN
    bad_par = 1'b0; CODE_PAR = 1'b1;
`endif
    // Expected values for dut0 (PULSE_LEN=4, GAP_LEN=1) after each edge.
    tbl[0]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 1'b1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 3'd5, 8'h01, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 1'b0, 3'd5, 8'h01, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 1'b1, 3'd2, 8'h01, 1'b1, 1'b0, 1'b1, 8'd1};
    tbl[6]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[7]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[8]  = '{1'b1, 1'b1, 3'd2, 8'h04, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[9]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[10] = '{1'b1, 1'b1, 3'd3, 8'h00, 1'b0, 1'b1, 1'b1, 8'd1};
    tbl[11] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd1};

    for (int k = 0; k < 12; k++) begin
      step(tbl[k].rst, tbl[k].v, tbl[k].code);
      chk("tbl_data", 0, int'(data_o[0]), int'(tbl[k].data));
      chk("tbl_dv", 0, int'(dv_o[0]), int'(tbl[k].dv));
      chk("tbl_ready", 0, int'(rdy_o[0]), int'(tbl[k].rdy));
      chk("tbl_drop", 0, int'(drop_o[0]), int'(tbl[k].drop));
      chk("tbl_cnt", 0, int'(cnt_o[0]), int'(tbl[k].cnt));
    end

    // CODE changes after the accept edge must not alter the pulse.
    step(1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 3'd0);
    step(1'b1, 1'b1, 3'd6);
    chk("hold_code", 0, int'(data_o[0]), 8'h40);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 3'd1);
      chk("hold_code", 0, int'(data_o[0]), 8'h40);
    end
    step(1'b1, 1'b0, 3'd1);
    chk("hold_end", 0, int'(data_o[0]), 8'h00);

    // CODE_VALID held high with CODE=7: accepts every 6 edges, 5 drops between.
    step(1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 3'd0);
    step(1'b1, 1'b1, 3'd7);
    chk("cont_accept1", 0, int'(data_o[0]), 8'h80);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 3'd7);
    chk("cont_dropcnt", 0, int'(cnt_o[0]), 5);
    step(1'b1, 1'b1, 3'd7);
    chk("cont_accept2", 0, int'(data_o[0]), 8'h80);
    chk("cont_ready", 0, int'(rdy_o[0]), 0);

    // Saturation: keep offering codes well past 255 drops.
    for (int k = 0; k < 360; k++) step(1'b1, 1'b1, 3'(k));
    chk("sat_cnt", 0, int'(cnt_o[0]), 255);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 3'd4);
    chk("sat_hold", 0, int'(cnt_o[0]), 255);

`ifdef DECODER_PULSE_PARITY_EN
    step(1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 3'd0);
    bad_par = 1'b1;
    step(1'b1, 1'b1, 3'd3);
    chk("par_bad_err", 0, int'(perr_o[0]), 1);
    chk("par_bad_data", 0, int'(data_o[0]), 0);
    bad_par = 1'b0;
    step(1'b1, 1'b1, 3'd3);
    chk("par_ok_data", 0, int'(data_o[0]), 8'h08);
    chk("par_ok_err", 0, int'(perr_o[0]), 0);
`endif

    // Randomized traffic with occasional resets.
    step(1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 1500; k++) begin
`ifdef DECODER_PULSE_PARITY_EN
      bad_par = ($urandom_range(0, 4) == 0);
`endif
      step($urandom_range(0, 79) != 0, $urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
